// File: rtl/huc_sram_resp.sv
// huc_sram_resp -- memory-side responder for the HuCard mapper request bus.
//
// Turns the mapper's level strobes (req_ce/req_oe/req_we) into timed cycles
// on an external asynchronous 8-bit SRAM/PSRAM. Every SRAM-side output is a
// register, so there is no combinational path from req_* to sram_*.
// A one-deep pending slot holds a request that arrives while a cycle runs.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   req_ce/oe/we          mapper chip-select and read/write level strobes
//   req_addr, req_dati    request address and write data (latched at the edge)
//   req_dato              last read data, held until the next read completes
//   busy                  cycle in progress or pending slot occupied
//   rd_done, wr_done      one-cycle completion pulses
//   ovf                   sticky: a request was dropped; cleared only by rst
//   sram_addr/dq_o/dq_oe  SRAM address, write data and its drive enable
//   sram_dq_i             SRAM read data
//   sram_ce_n/oe_n/we_n   SRAM strobes, active low
module huc_sram_resp #(
   parameter int ADDR_W  = 20,
   parameter int RD_WAIT = 3,
   parameter int WR_WAIT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_ce,
   input  logic              req_oe,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [7:0]        req_dati,
   output logic [7:0]        req_dato,
   output logic              busy,
   output logic              rd_done,
   output logic              wr_done,
   output logic              ovf,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [7:0]        sram_dq_o,
   output logic              sram_dq_oe,
   input  logic [7:0]        sram_dq_i,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n
);

   localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
   localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

   typedef enum logic [2:0] {IDLE, RD, WR, WHOLD, RECOV} state_t;

   state_t              state, state_nx;
   logic [CNT_W-1:0]    cnt, cnt_nx;
   logic                prev_rd, prev_wr;
   logic                pend_v, pend_v_nx, pend_wr, pend_wr_nx;
   logic [ADDR_W-1:0]   pend_addr, pend_addr_nx;
   logic [7:0]          pend_data, pend_data_nx;
   logic [7:0]          req_dato_nx;
   logic                rd_done_nx, wr_done_nx, ovf_nx;
   logic [ADDR_W-1:0]   sram_addr_nx;
   logic [7:0]          sram_dq_o_nx;
   logic                sram_dq_oe_nx, sram_ce_n_nx, sram_oe_n_nx, sram_we_n_nx;

   logic                rd_lvl, wr_lvl, rd_edge, wr_edge, new_req, new_wr;
   logic                go, go_wr, new_taken, slot_free;
   logic [ADDR_W-1:0]   go_addr;
   logic [7:0]          go_data;

   assign rd_lvl  = req_ce & req_oe;
   assign wr_lvl  = req_ce & req_we;
   assign rd_edge = rd_lvl & ~prev_rd;
   assign wr_edge = wr_lvl & ~prev_wr;
   assign new_req = rd_edge | wr_edge;
   // A simultaneous read/write edge keeps the read only.
   assign new_wr  = ~rd_edge;

   assign busy = (state != IDLE) | pend_v;

   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      req_dato_nx   = req_dato;
      rd_done_nx    = 1'b0;
      wr_done_nx    = 1'b0;
      ovf_nx        = ovf | (rd_edge & wr_edge);
      sram_addr_nx  = sram_addr;
      sram_dq_o_nx  = sram_dq_o;
      sram_dq_oe_nx = sram_dq_oe;
      sram_ce_n_nx  = sram_ce_n;
      sram_oe_n_nx  = sram_oe_n;
      sram_we_n_nx  = sram_we_n;
      pend_wr_nx    = pend_wr;
      pend_addr_nx  = pend_addr;
      pend_data_nx  = pend_data;
      go            = 1'b0;
      go_wr         = pend_wr;
      go_addr       = pend_addr;
      go_data       = pend_data;
      new_taken     = 1'b0;
      slot_free     = ~pend_v;

      case (state)
         // RECOV already has every strobe high, so its exit edge may launch
         // the next cycle directly; this gives the N+RD_WAIT+1 / N+WR_WAIT+2
         // turnaround instead of spending an extra cycle in IDLE.
         IDLE, RECOV: begin
            state_nx = IDLE;
            if (pend_v) begin
               go        = 1'b1;
               slot_free = 1'b1;
            end else if (new_req) begin
               go        = 1'b1;
               go_wr     = new_wr;
               go_addr   = req_addr;
               go_data   = req_dati;
               new_taken = 1'b1;
            end
         end
         RD: begin
            if (cnt == '0) begin
               req_dato_nx  = sram_dq_i;
               rd_done_nx   = 1'b1;
               sram_ce_n_nx = 1'b1;
               sram_oe_n_nx = 1'b1;
               state_nx     = RECOV;
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         WR: begin
            if (cnt == '0) begin
               sram_we_n_nx = 1'b1;
               sram_ce_n_nx = 1'b1;
               wr_done_nx   = 1'b1;
               state_nx     = WHOLD;
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         WHOLD: begin
            // Data stays driven one cycle past we_n rising for hold time.
            sram_dq_oe_nx = 1'b0;
            state_nx      = RECOV;
         end
         default: state_nx = IDLE;
      endcase

      if (go) begin
         sram_addr_nx = go_addr;
         sram_ce_n_nx = 1'b0;
         if (go_wr) begin
            state_nx      = WR;
            cnt_nx        = CNT_W'(WR_WAIT - 1);
            sram_we_n_nx  = 1'b0;
            sram_dq_oe_nx = 1'b1;
            sram_dq_o_nx  = go_data;
         end else begin
            state_nx     = RD;
            cnt_nx       = CNT_W'(RD_WAIT - 1);
            sram_oe_n_nx = 1'b0;
         end
      end

      // A slot freed by dispatch this edge can be refilled by the same edge.
      pend_v_nx = pend_v & ~slot_free;
      if (new_req && !new_taken) begin
         if (slot_free) begin
            pend_v_nx    = 1'b1;
            pend_wr_nx   = new_wr;
            pend_addr_nx = req_addr;
            pend_data_nx = req_dati;
         end else begin
            ovf_nx = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         prev_rd    <= 1'b0;
         prev_wr    <= 1'b0;
         pend_v     <= 1'b0;
         pend_wr    <= 1'b0;
         pend_addr  <= '0;
         pend_data  <= '0;
         req_dato   <= 8'hFF;
         rd_done    <= 1'b0;
         wr_done    <= 1'b0;
         ovf        <= 1'b0;
         sram_addr  <= '0;
         sram_dq_o  <= '0;
         sram_dq_oe <= 1'b0;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         prev_rd    <= rd_lvl;
         prev_wr    <= wr_lvl;
         pend_v     <= pend_v_nx;
         pend_wr    <= pend_wr_nx;
         pend_addr  <= pend_addr_nx;
         pend_data  <= pend_data_nx;
         req_dato   <= req_dato_nx;
         rd_done    <= rd_done_nx;
         wr_done    <= wr_done_nx;
         ovf        <= ovf_nx;
         sram_addr  <= sram_addr_nx;
         sram_dq_o  <= sram_dq_o_nx;
         sram_dq_oe <= sram_dq_oe_nx;
         sram_ce_n  <= sram_ce_n_nx;
         sram_oe_n  <= sram_oe_n_nx;
         sram_we_n  <= sram_we_n_nx;
      end
   end

endmodule
